spindash_mixer: RTL and testbench



---
 rtl/spindash_mixer.sv | 224 ++++++++++++++++++++++
 tb/tb_spindash_mixer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spindash_mixer.sv
// Time-multiplexed stereo mixer: one shared MAC per channel walks the chip snapshot, then shifts and saturates.
// Optional clip counter output enabled by defining SPINDASH_MIXER_CLIP_COUNT_EN.

module spindash_mixer_lane #(
    parameter int IN_W   = 16,
    parameter int GAIN_W = 8,
    parameter int OUT_W  = 18,
    parameter int ACC_W  = 29
) (
    input  logic                     clk_jt,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic                     i_fin,
    input  logic        [IN_W-1:0]   i_smp,
    input  logic        [GAIN_W-1:0] i_gain,
    output logic signed [OUT_W-1:0]  o_out,
    output logic                     o_sat
);
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0]       r_acc;
    logic signed [OUT_W-1:0]       r_out;
    logic signed [IN_W+GAIN_W:0]   w_prod;
    logic signed [ACC_W-1:0]       w_prod_x;
    logic signed [ACC_W-1:0]       w_shr;
    logic                          w_hi;
    logic                          w_lo;
    logic signed [OUT_W-1:0]       w_sat_val;

    // Gain is unsigned: a zero MSB keeps it positive in the signed multiply.
    assign w_prod    = $signed(i_smp) * $signed({1'b0, i_gain});
    assign w_prod_x  = ACC_W'(w_prod);
    assign w_shr     = r_acc >>> (GAIN_W - 1);
    assign w_hi      = w_shr > SAT_HI;
    assign w_lo      = w_shr < SAT_LO;
    assign w_sat_val = w_hi ? SAT_HI[OUT_W-1:0] : (w_lo ? SAT_LO[OUT_W-1:0] : w_shr[OUT_W-1:0]);
    assign o_sat     = w_hi | w_lo;
    assign o_out     = r_out;

    // On a back-to-back sample, fin and clr share an edge: the result reads the old accumulator.
    always_ff @(posedge clk_jt) begin
        if (rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else begin
            if (i_clr)
                r_acc <= '0;
            else if (i_en)
                r_acc <= r_acc + w_prod_x;
            if (i_fin)
                r_out <= w_sat_val;
        end
    end
endmodule

module spindash_mixer #(
    parameter int CHIPS  = 9,
    parameter int IN_W   = 16,
    parameter int GAIN_W = 8,
    parameter int OUT_W  = 18
) (
    input  logic                      clk_jt,
    input  logic                      rst,
    input  logic                      sample_in,
    input  logic [CHIPS*IN_W-1:0]     snd_left_flat,
    input  logic [CHIPS*IN_W-1:0]     snd_right_flat,
    input  logic                      gain_we,
    input  logic [4:0]                gain_addr,
    input  logic [GAIN_W-1:0]         gain_data,
    output logic signed [OUT_W-1:0]   out_left,
    output logic signed [OUT_W-1:0]   out_right,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
`ifdef SPINDASH_MIXER_CLIP_COUNT_EN
    ,
    output logic [15:0]               clip_count
`endif
);
    localparam int ACC_W = IN_W + GAIN_W + $clog2(CHIPS) + 1;
    localparam int IDX_W = (CHIPS > 1) ? $clog2(CHIPS) : 1;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = {1'b1, {(GAIN_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH} state_t;

    state_t                         r_state, w_state_nxt;
    logic [IDX_W-1:0]               r_idx, w_idx_nxt;
    logic                           r_busy, w_busy_nxt;
    logic                           r_valid;
    logic                           r_overrun;
    logic [CHIPS-1:0][GAIN_W-1:0]   r_gain;
    logic [CHIPS-1:0][GAIN_W-1:0]   r_snap_g;
    logic [CHIPS-1:0][IN_W-1:0]     r_snap_l;
    logic [CHIPS-1:0][IN_W-1:0]     r_snap_r;
    logic                           w_snap;
    logic                           w_en;
    logic                           w_fin;
    logic [1:0][IN_W-1:0]           w_lane_smp;
    logic [GAIN_W-1:0]              w_lane_gain;
    logic [1:0][OUT_W-1:0]          w_lane_out;
    logic [1:0]                     w_lane_sat;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        w_snap      = 1'b0;
        w_en        = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_in) begin
                    w_snap      = 1'b1;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_en = 1'b1;
                if (r_idx == IDX_W'(CHIPS - 1))
                    w_state_nxt = S_FINISH;
                else
                    w_idx_nxt = r_idx + 1'b1;
            end
            S_FINISH: begin
                w_fin       = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
                // Next sample may land on the result edge so the period can be CHIPS+1.
                if (sample_in) begin
                    w_snap      = 1'b1;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_ACCUM;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_jt) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_snap_g  <= '0;
            r_snap_l  <= '0;
            r_snap_r  <= '0;
            for (int i = 0; i < CHIPS; i++)
                r_gain[i] <= GAIN_UNITY;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_fin;
            if (sample_in && r_state == S_ACCUM)
                r_overrun <= 1'b1;
            // Snapshot sees the gain file before any write on the same edge.
            if (w_snap) begin
                r_snap_l <= snd_left_flat;
                r_snap_r <= snd_right_flat;
                r_snap_g <= r_gain;
            end
            for (int i = 0; i < CHIPS; i++)
                if (gain_we && gain_addr == 5'(i))
                    r_gain[i] <= gain_data;
        end
    end

    always_comb begin
        w_lane_smp  = '0;
        w_lane_gain = '0;
        for (int i = 0; i < CHIPS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_lane_smp[0] = r_snap_l[i];
                w_lane_smp[1] = r_snap_r[i];
                w_lane_gain   = r_snap_g[i];
            end
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_lane
        logic signed [OUT_W-1:0] w_out;
        spindash_mixer_lane #(
            .IN_W   (IN_W),
            .GAIN_W (GAIN_W),
            .OUT_W  (OUT_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk_jt (clk_jt),
            .rst    (rst),
            .i_clr  (w_snap),
            .i_en   (w_en),
            .i_fin  (w_fin),
            .i_smp  (w_lane_smp[ch]),
            .i_gain (w_lane_gain),
            .o_out  (w_out),
            .o_sat  (w_lane_sat[ch])
        );
        assign w_lane_out[ch] = w_out;
    end

    assign out_left  = w_lane_out[0];
    assign out_right = w_lane_out[1];
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

`ifdef SPINDASH_MIXER_CLIP_COUNT_EN
    logic [15:0] r_clip;
    always_ff @(posedge clk_jt) begin
        if (rst)
            r_clip <= '0;
        else if (w_fin && (|w_lane_sat) && r_clip != 16'hFFFF)
            r_clip <= r_clip + 16'd1;
    end
    assign clip_count = r_clip;
`endif
endmodule

// File: tb/tb_spindash_mixer.sv
// Bench for spindash_mixer: constant vector table, hand sequences for timing corners, random mixes vs a sum/floor/clamp model.
module tb_spindash_mixer;
    localparam int CHIPS = 9, IN_W = 16, GAIN_W = 8, OUT_W = 18;

    logic                    clk_jt = 1'b0;
    logic                    rst = 1'b1;
    logic                    sample_in = 1'b0;
    logic [CHIPS*IN_W-1:0]   snd_left_flat = '0;
    logic [CHIPS*IN_W-1:0]   snd_right_flat = '0;
    logic                    gain_we = 1'b0;
    logic [4:0]              gain_addr = '0;
    logic [GAIN_W-1:0]       gain_data = '0;
    logic signed [OUT_W-1:0] out_left, out_right;
    logic                    out_valid, busy, overrun;
`ifdef SPINDASH_MIXER_CLIP_COUNT_EN
    logic [15:0]             clip_count;
`endif

    spindash_mixer #(.CHIPS(CHIPS), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) dut (
        .clk_jt(clk_jt), .rst(rst), .sample_in(sample_in),
        .snd_left_flat(snd_left_flat), .snd_right_flat(snd_right_flat),
        .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data),
        .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
`ifdef SPINDASH_MIXER_CLIP_COUNT_EN
        , .clip_count(clip_count)
`endif
    );

    always #5 clk_jt = ~clk_jt;

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    typedef struct { int l; int r; int g; bit g0_only; longint el; longint er; } vec_t;

    int n_vec = 0, n_bad = 0;
    int sl[CHIPS], sr[CHIPS], gm[CHIPS];

    task automatic tick();
        @(posedge clk_jt); #1;
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < CHIPS; i++) begin
            snd_left_flat[i*IN_W +: IN_W]  = IN_W'(sl[i]);
            snd_right_flat[i*IN_W +: IN_W] = IN_W'(sr[i]);
        end
    endtask

    task automatic set_all(input int l, input int r);
        for (int i = 0; i < CHIPS; i++) begin sl[i] = l; sr[i] = r; end
        pack();
    endtask

    task automatic gw(input int a, input int d);
        gain_we = 1'b1; gain_addr = 5'(a); gain_data = GAIN_W'(d);
        tick();
        gain_we = 1'b0;
        if (a < CHIPS) gm[a] = d;
    endtask

    // Weighted sum, floor-divide by unity gain, clamp to the output range.
    function automatic longint ref_mix(input bit right);
        longint sum, unity, q, hi, lo;
        sum = 0;
        unity = longint'(1) << (GAIN_W - 1);
        for (int i = 0; i < CHIPS; i++)
            sum += longint'(right ? sr[i] : sl[i]) * longint'(gm[i]);
        q = sum / unity;
        if (sum < 0 && (sum % unity) != 0) q -= 1;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    task automatic do_mix(input bit gwe, input int ga, input int gd,
                          output longint ol, output longint orr, output int lat, output int bn);
        pack();
        gain_we = gwe; gain_addr = 5'(ga); gain_data = GAIN_W'(gd);
        sample_in = 1'b1;
        tick();
        sample_in = 1'b0; gain_we = 1'b0;
        if (gwe && ga < CHIPS) gm[ga] = gd;
        bn = busy ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (busy) bn++;
            if (out_valid) begin lat = k; break; end
        end
        ol = longint'(out_left);
        orr = longint'(out_right);
    endtask

    initial begin
        vec_t   vt[6];
        longint ol, orr, v1l, v2l;
        int     lat, bn, nv, e1, e2;

        vt[0] = '{1000, -1000, 128, 1'b0, 9000, -9000};
        vt[1] = '{1001, -1001, 64, 1'b1, 500, -501};
        vt[2] = '{1, -1, 1, 1'b0, 0, -1};
        vt[3] = '{32767, 32767, 255, 1'b0, 131071, 131071};
        vt[4] = '{-32768, -32768, 255, 1'b0, -131072, -131072};
        vt[5] = '{-3, 5, 200, 1'b0, -43, 70};

        for (int i = 0; i < CHIPS; i++) gm[i] = 128;
        tick(); tick();
        chk("rst_out_left", longint'(out_left), 0);
        chk("rst_out_right", longint'(out_right), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_overrun", longint'(overrun), 0);
        rst = 1'b0;
        tick();

        // Unity gains straight out of reset.
        set_all(1000, -1000);
        do_mix(1'b0, 0, 0, ol, orr, lat, bn);
        chk("reset_gain_mix_l", ol, 9000);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < CHIPS; i++)
                gw(i, (vt[v].g0_only && i != 0) ? 0 : vt[v].g);
            set_all(vt[v].l, vt[v].r);
            do_mix(1'b0, 0, 0, ol, orr, lat, bn);
            chk($sformatf("vec%0d_left", v), ol, vt[v].el);
            chk($sformatf("vec%0d_right", v), orr, vt[v].er);
            chk($sformatf("vec%0d_latency", v), lat, CHIPS + 1);
            chk($sformatf("vec%0d_busy_cycles", v), bn, CHIPS + 1);
        end
`ifdef SPINDASH_MIXER_CLIP_COUNT_EN
        chk("clip_count_after_table", longint'(clip_count), 2);
`endif

        // Overrun: extra strobe mid-mix ignored, strobe on the result edge accepted.
        for (int i = 0; i < CHIPS; i++) gw(i, 128);
        set_all(1000, -1000);
        nv = 0; e1 = -1; e2 = -1; v1l = -1; v2l = -1;
        for (int e = 0; e <= 25; e++) begin
            if (e == 4) set_all(5, 5);
            if (e == 10) set_all(2000, -2000);
            sample_in = (e == 0 || e == 4 || e == 10);
            tick();
            sample_in = 1'b0;
            if (out_valid) begin
                nv++;
                if (e1 < 0) begin e1 = e; v1l = longint'(out_left); end
                else begin e2 = e; v2l = longint'(out_left); end
            end
            if (e == 3) chk("overrun_before", longint'(overrun), 0);
            if (e == 5) chk("overrun_set", longint'(overrun), 1);
        end
        chk("overrun_valid_count", nv, 2);
        chk("overrun_first_edge", e1, 10);
        chk("overrun_second_edge", e2, 20);
        chk("overrun_first_value", v1l, 9000);
        chk("overrun_second_value", v2l, 18000);
        chk("overrun_sticky", longint'(overrun), 1);

        // Gain write on edge 0 affects only the next sample; bad addresses are ignored.
        set_all(1000, -1000);
        do_mix(1'b1, 2, 0, ol, orr, lat, bn);
        chk("gain_edge0_left", ol, 9000);
        do_mix(1'b0, 0, 0, ol, orr, lat, bn);
        chk("gain_next_left", ol, 8000);
        chk("gain_next_right", orr, -8000);
        gw(12, 0);
        gw(9, 0);
        do_mix(1'b0, 0, 0, ol, orr, lat, bn);
        chk("gain_bad_addr_left", ol, 8000);

        // Reset in the middle of ACCUM.
        pack();
        sample_in = 1'b1; tick(); sample_in = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        nv = 0;
        for (int k = 0; k < 15; k++) begin tick(); if (out_valid) nv++; end
        chk("rstmid_no_valid", nv, 0);
        chk("rstmid_out_left", longint'(out_left), 0);
        chk("rstmid_out_right", longint'(out_right), 0);
        chk("rstmid_busy", longint'(busy), 0);
        chk("rstmid_overrun", longint'(overrun), 0);
`ifdef SPINDASH_MIXER_CLIP_COUNT_EN
        chk("rstmid_clip_count", longint'(clip_count), 0);
`endif
        for (int i = 0; i < CHIPS; i++) gm[i] = 128;
        do_mix(1'b0, 0, 0, ol, orr, lat, bn);
        chk("rstmid_after_left", ol, 9000);
        chk("rstmid_after_right", orr, -9000);

        // Randomized mixes against the model.
        for (int it = 0; it < 24; it++) begin
            for (int w = 0; w < 3; w++)
                gw(int'($urandom_range(15)), int'($urandom_range(255)));
            for (int i = 0; i < CHIPS; i++) begin
                if (it % 4 == 0) begin
                    sl[i] = ($urandom_range(1) != 0) ? 32767 : -32768;
                    sr[i] = ($urandom_range(1) != 0) ? 32767 : -32768;
                end else begin
                    sl[i] = int'($urandom_range(65535)) - 32768;
                    sr[i] = int'($urandom_range(65535)) - 32768;
                end
            end
            do_mix(1'b0, 0, 0, ol, orr, lat, bn);
            chk($sformatf("rand%0d_left", it), ol, ref_mix(1'b0));
            chk($sformatf("rand%0d_right", it), orr, ref_mix(1'b1));
            chk($sformatf("rand%0d_latency", it), lat, CHIPS + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
